wb_grf: RTL
===========

Name: wb_grf

Overview:
- W-stage consumer of the MEM/WB pipeline register.
- Decodes the W-stage instruction, selects and load-extends the write-back data, and commits it to the 32x32 general register file.
- Serves the two D-stage read ports with internal write-to-read bypass.
- Exports the write-back address and data so the hazard/forwarding unit can forward from W.

Parameters:
- DW, 32, datapath width.
- NREG, 32, register count; register 0 is hardwired to zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all registers.
- RegWrite_W  in  1  write enable from the MEM/WB register.
- Mem2Reg_W  in  2  data source: 0 = ALU_C_W, 1 = extended DM_out_W, 2 = pc8_W, 3 = reserved (treated as 0).
- regdst_W  in  2  destination: 0 = IR_W[20:16] (rt), 1 = IR_W[15:11] (rd), 2 = 31, 3 = reserved (treated as 0).
- IR_W  in  32  W-stage instruction; opcode IR_W[31:26] selects the load type.
- pc_W  in  32  W-stage PC; used by the trace feature only.
- pc8_W  in  32  link value.
- DM_out_W  in  32  raw data-memory word.
- ALU_C_W  in  32  ALU result; bits [1:0] give the byte offset for loads.
- A1  in  5  read address, port 1 (D stage).
- A2  in  5  read address, port 2 (D stage).
- RD1  out  32  read data, port 1.
- RD2  out  32  read data, port 2.
- WA_W  out  5  effective write address (0 when no write).
- WD_W  out  32  final write-back data.

Behaviour:
- Load extension, applied only when Mem2Reg_W = 1. Opcode decode:
  - 100011 lw: word unchanged.
  - 100000 lb: byte DM_out_W[8*off+7 : 8*off], sign-extended.
  - 100100 lbu: same byte, zero-extended.
  - 100001 lh: half selected by ALU_C_W[1], sign-extended.
  - 100101 lhu: same half, zero-extended.
  - Any other opcode: word unchanged.
  - off = ALU_C_W[1:0]. ALU_C_W[0] is ignored for halfwords; alignment is checked upstream.
- WD_W: combinational mux over Mem2Reg_W as listed in Ports.
- WA_W: the regdst_W mux result when RegWrite_W = 1, else 0.
- Write effective (we_eff) = RegWrite_W && WA_W != 0 && !reset.
- Commit: on the rising clk edge with we_eff high, reg[WA_W] <= WD_W. Latency is one edge; the value is architecturally visible from the following cycle.
- Reads are combinational: RDn = 0 if An = 0; else WD_W if we_eff && An == WA_W (same-cycle bypass); else reg[An].
- Writes to register 0 are dropped, and register 0 always reads 0, including under bypass.
- Both ports may read the same address, or the write address, in the same cycle; each port resolves independently.
- Reset (asynchronous):
  - All registers clear to 0 immediately, independent of clk.
  - While reset is high: bypass is disabled, RD1 = RD2 = 0, and no write occurs.
  - WA_W and WD_W stay purely combinational from their inputs.
- A write whose edge coincides with reset asserted is lost.
- Deassertion of reset takes effect at the next clk edge with no extra wait state.
- No X propagation: the reserved mux codes resolve to 0.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: at each rising clk edge with we_eff high, a simulation-only $display prints "@<pc_W hex 8>: $<WA_W dec 2> <= <WD_W hex 8>", with time prefix "%d@" per the course grader format. Writes to $0 are not printed.
- Undefined: no display code is compiled and the block is fully synthesizable.
- Functional behaviour is identical either way.

Decomposition:
- Shared package:
  - Mem2Reg codes: M2R_ALU, M2R_DM, M2R_PC8.
  - regdst codes: DST_RT, DST_RD, DST_RA.
  - Load opcodes: OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU.
  - Register 31 constant: REG_RA.
- Sub-module: load_ext (combinational extension taking IR_W opcode, offset and DM_out_W). The top holds the muxes, the register array and the bypass.

Test Plan:
- Reset then read: assert reset mid-simulation, asynchronously between edges -> all 32 registers read 0 immediately; RD1 = RD2 = 0 while reset is high.
- ALU write plus bypass: RegWrite_W = 1, regdst_W = 1, IR_W[15:11] = 8, Mem2Reg_W = 0, ALU_C_W = 0x12345678, A1 = 8 in the same cycle -> RD1 = 0x12345678 before the edge; reg[8] holds it after the edge.
- Load extension: DM_out_W = 0x80FF7F01.
  - lb with off = 1 -> WD_W = 0x0000007F.
  - lb with off = 3 -> 0xFFFFFF80.
  - lbu with off = 3 -> 0x00000080.
  - lh with off = 2 -> 0xFFFF80FF.
  - lhu with off = 0 -> 0x00007F01.
- Link write: regdst_W = 2, Mem2Reg_W = 2, pc8_W = 0x00003008 -> WA_W = 31 and reg[31] = 0x00003008 after the edge.
- $0 protection: RegWrite_W = 1, dest = 0, WD_W = 0xDEADBEEF, A1 = A2 = 0 -> RD1 = RD2 = 0 in the same cycle and after the edge; WA_W = 0.
- Write disabled: RegWrite_W = 0 with dest 5 -> WA_W = 0; reg[5] is unchanged and no bypass is applied to A1 = 5.

Source files
------------

// File: rtl/wb_grf_pkg.sv
// wb_grf_pkg: shared constants for the W-stage write-back / register-file slice.
//   - Mem2Reg_W source codes (M2R_*)
//   - regdst_W destination codes (DST_*)
//   - load opcodes decoded for load extension (OP_*)
//   - REG_RA: link register index
package wb_grf_pkg;

  localparam int DW_C   = 32;
  localparam int NREG_C = 32;
  localparam int AW_C   = 5;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_DM  = 2'd1;
  localparam logic [1:0] M2R_PC8 = 2'd2;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_RA  = 2'd2;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LHU  = 6'b100101;

  localparam logic [4:0] REG_RA  = 5'd31;

endpackage

// File: rtl/wb_grf_if.sv
// wb_grf_if: bundles the MEM/WB-register inputs, the D-stage read ports and
// the W-stage forwarding outputs of wb_grf.
//   master: drives RegWrite_W, Mem2Reg_W, regdst_W, IR_W, pc_W, pc8_W,
//           DM_out_W, ALU_C_W, A1, A2; receives RD1, RD2, WA_W, WD_W.
//   slave : the register file side (wb_grf).
interface wb_grf_if;
  import wb_grf_pkg::*;

  logic                 RegWrite_W;
  logic [1:0]           Mem2Reg_W;
  logic [1:0]           regdst_W;
  logic [DW_C-1:0]      IR_W;
  logic [DW_C-1:0]      pc_W;
  logic [DW_C-1:0]      pc8_W;
  logic [DW_C-1:0]      DM_out_W;
  logic [DW_C-1:0]      ALU_C_W;
  logic [AW_C-1:0]      A1;
  logic [AW_C-1:0]      A2;
  logic [DW_C-1:0]      RD1;
  logic [DW_C-1:0]      RD2;
  logic [AW_C-1:0]      WA_W;
  logic [DW_C-1:0]      WD_W;

  modport master (
    output RegWrite_W, Mem2Reg_W, regdst_W, IR_W, pc_W, pc8_W, DM_out_W, ALU_C_W, A1, A2,
    input  RD1, RD2, WA_W, WD_W
  );

  modport slave (
    input  RegWrite_W, Mem2Reg_W, regdst_W, IR_W, pc_W, pc8_W, DM_out_W, ALU_C_W, A1, A2,
    output RD1, RD2, WA_W, WD_W
  );

endinterface

// File: rtl/wb_grf_load_ext.sv
// wb_grf_load_ext: combinational load extension of the raw data-memory word.
//   opcode : IR_W[31:26], selects lw/lb/lbu/lh/lhu (others pass the word)
//   off    : ALU_C_W[1:0] byte offset (off[0] ignored for halfwords)
//   dm     : raw data-memory word
//   ext    : extended load data
module wb_grf_load_ext
  import wb_grf_pkg::*;
(
  input  logic [5:0]      opcode,
  input  logic [1:0]      off,
  input  logic [DW_C-1:0] dm,
  output logic [DW_C-1:0] ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte and halfword lane selection from the offset.
  always_comb begin
    byte_s = 8'd0;
    case (off)
      2'd0:    byte_s = dm[7:0];
      2'd1:    byte_s = dm[15:8];
      2'd2:    byte_s = dm[23:16];
      2'd3:    byte_s = dm[31:24];
      default: byte_s = 8'd0;
    endcase
    if (off[1]) begin
      half_s = dm[31:16];
    end else begin
      half_s = dm[15:0];
    end
  end

  // Sign/zero extension by load opcode; unknown opcodes pass the word.
  always_comb begin
    ext = dm;
    case (opcode)
      OP_LW:   ext = dm;
      OP_LB:   ext = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  ext = {24'd0, byte_s};
      OP_LH:   ext = {{16{half_s[15]}}, half_s};
      OP_LHU:  ext = {16'd0, half_s};
      default: ext = dm;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// wb_grf: W-stage write-back and 32x32 general register file.
//   clk   : rising-edge clock
//   reset : asynchronous active-high, clears every register
//   bus   : wb_grf_if.slave (MEM/WB inputs, D-stage reads, WA_W/WD_W export)
// Register 0 is hardwired to zero. Reads are combinational with a same-cycle
// write-to-read bypass, disabled while reset is high.
// Optional macro WB_TRACE_EN: prints a grader-format trace line per
// effective write (simulation only); functional behaviour is unchanged.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input logic       clk,
  input logic       reset,
  wb_grf_if.slave   bus
);

  logic [DW-1:0]   regs_r [NREG];
  logic [DW-1:0]   ext_s;
  logic [DW-1:0]   wd_s;
  logic [AW_C-1:0] dst_s;
  logic [AW_C-1:0] wa_s;
  logic            we_eff_s;
  logic [DW-1:0]   rd1_s;
  logic [DW-1:0]   rd2_s;

  wb_grf_load_ext u_load_ext (
    .opcode (bus.IR_W[31:26]),
    .off    (bus.ALU_C_W[1:0]),
    .dm     (bus.DM_out_W),
    .ext    (ext_s)
  );

  // Write-back data and destination muxes; reserved codes resolve to zero.
  always_comb begin
    wd_s = '0;
    case (bus.Mem2Reg_W)
      M2R_ALU: wd_s = bus.ALU_C_W;
      M2R_DM:  wd_s = ext_s;
      M2R_PC8: wd_s = bus.pc8_W;
      default: wd_s = '0;
    endcase
    dst_s = 5'd0;
    case (bus.regdst_W)
      DST_RT:  dst_s = bus.IR_W[20:16];
      DST_RD:  dst_s = bus.IR_W[15:11];
      DST_RA:  dst_s = REG_RA;
      default: dst_s = 5'd0;
    endcase
    if (bus.RegWrite_W) begin
      wa_s = dst_s;
    end else begin
      wa_s = 5'd0;
    end
  end

  assign we_eff_s = bus.RegWrite_W && (wa_s != 5'd0) && !reset;

  // Read ports: $0 reads zero, bypass only on an effective write.
  always_comb begin
    if (reset || bus.A1 == 5'd0) begin
      rd1_s = '0;
    end else if (we_eff_s && bus.A1 == wa_s) begin
      rd1_s = wd_s;
    end else begin
      rd1_s = regs_r[bus.A1];
    end
    if (reset || bus.A2 == 5'd0) begin
      rd2_s = '0;
    end else if (we_eff_s && bus.A2 == wa_s) begin
      rd2_s = wd_s;
    end else begin
      rd2_s = regs_r[bus.A2];
    end
  end

  // Register array commit; $0 is never written because we_eff excludes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we_eff_s) begin
      regs_r[wa_s] <= wd_s;
    end
  end

  assign bus.RD1  = rd1_s;
  assign bus.RD2  = rd2_s;
  assign bus.WA_W = wa_s;
  assign bus.WD_W = wd_s;

  // Instruction fields not consumed by the write-back path.
  logic unused_ir_s;
  assign unused_ir_s = ^{bus.IR_W[25:21], bus.IR_W[10:0]};

`ifdef WB_TRACE_EN
  // Grader-format trace of every effective write.
  always_ff @(posedge clk) begin
    if (we_eff_s) begin
      $display("%d@%h: $%2d <= %h", $time, bus.pc_W, wa_s, wd_s);
    end
  end
`else
  logic unused_pc_s;
  assign unused_pc_s = ^bus.pc_W;
`endif

endmodule
